mem_arbiter_nch: RTL and testbench

// Parametrised successor of the two-client memory controller: arbitrates NUM_CH load/store/fetch

---
 rtl/mem_arbiter_nch_pkg.sv | 27 ++
 rtl/mem_arbiter_nch_rr_arbiter.sv | 45 ++++
 rtl/mem_arbiter_nch.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter_nch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_nch_pkg.sv
// Shared encodings for the N-channel byte-serial memory arbiter.
// Length codes, IO window tag, FSM states and byte-count helper.
package mem_arbiter_nch_pkg;

   localparam logic [1:0] LEN_1B = 2'b00;
   localparam logic [1:0] LEN_2B = 2'b01;
   localparam logic [1:0] LEN_4B = 2'b10;
   localparam logic [1:0] IO_HI  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_XFER = 2'b01,
      ST_TAIL = 2'b10
   } state_t;

   // 2'b11 is treated like a full word
   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      logic [2:0] n;
      unique case (1'b1)
         (len == LEN_1B): n = 3'd1;
         (len == LEN_2B): n = 3'd2;
         default:         n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_arbiter_nch_rr_arbiter.sv
// Round-robin arbiter: lowest requester above the last grant, wrapping.
// Pointer starts at N-1 so channel 0 wins first after reset.
module rr_arbiter
   import mem_arbiter_nch_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          grant_en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW-1:0] last_q;
   int            j;

   // scan from last+1 upward with wrap, first hit wins
   always_comb begin
      grant = '0;
      idx   = last_q;
      valid = 1'b0;
      j     = 0;
      for (int off = 1; off <= N; off++) begin
         j = (int'(last_q) + off) % N;
         if (!valid && req[j]) begin
            valid    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

   // remember the winner only when the grant is taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_q <= IW'(N - 1);
      else if (grant_en && valid)
         last_q <= idx;
   end

endmodule

// File: rtl/mem_arbiter_nch.sv
// N-channel arbiter onto the byte-serial RAM/IO bus with 1/2/4 B words.
// Handles flush aborts, UART-full write stalls and rdy-freeze recovery.
module mem_arbiter_nch
   import mem_arbiter_nch_pkg::*;
#(
   parameter int                 NUM_CH     = 2,
   parameter int                 ADDR_W     = 32,
   parameter logic [NUM_CH-1:0]  FLUSH_MASK = 'b01
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     clr,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_we,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*2-1:0]      ch_len,
   input  logic [NUM_CH*32-1:0]     ch_wdata,
   output logic [NUM_CH-1:0]        ch_ack,
   output logic [31:0]              ch_rdata,
   input  logic [7:0]               mem_din,
   output logic [7:0]               mem_dout,
   output logic [ADDR_W-1:0]        mem_a,
   output logic                     mem_wr,
   input  logic                     io_buffer_full
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          nb_q;
   logic                we_q;
   logic [31:0]         wdata_q;
   logic [IW-1:0]       ch_q;
   logic [2:0]          cnt_q;
   logic [31:0]         buf_q;
   logic [31:0]         rdata_q;
   logic [NUM_CH-1:0]   ack_q;

   logic [NUM_CH-1:0]   req_eff;
   logic [NUM_CH-1:0]   gnt;
   logic [IW-1:0]       gnt_idx;
   logic                gnt_vld;
   logic                gnt_en;
   logic [ADDR_W-1:0]   sel_addr;
   logic [1:0]          sel_len;
   logic                sel_we;
   logic [31:0]         sel_wd;
   logic [NUM_CH-1:0]   ack_one;
   logic                io_stall;
   logic                abort;
   logic                last;
   logic [1:0]          sidx;
   logic [4:0]          rsh;
   logic [31:0]         buf_nx;
   logic [31:0]         wsh;

   assign req_eff  = ch_req & ~ack_q & ~({NUM_CH{clr}} & FLUSH_MASK);
   assign gnt_en   = rdy && (state_q == ST_IDLE);
   assign io_stall = we_q && (addr_q[17:16] == IO_HI) && io_buffer_full;
   assign abort    = clr && !we_q && FLUSH_MASK[ch_q] && (state_q != ST_IDLE);
   assign last     = (cnt_q == nb_q - 3'd1);
   assign sidx     = cnt_q[1:0] - 2'd1;
   assign rsh      = {sidx, 3'b000};
   assign buf_nx   = (buf_q & ~(32'hFF << rsh)) | (32'(mem_din) << rsh);
   assign wsh      = wdata_q >> {cnt_q[1:0], 3'b000};

   rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr (
      .clk      (clk),
      .rst      (rst),
      .req      (req_eff),
      .grant_en (gnt_en),
      .grant    (gnt),
      .idx      (gnt_idx),
      .valid    (gnt_vld)
   );

   // pick the granted channel's request fields
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      sel_we   = 1'b0;
      sel_wd   = '0;
      ack_one  = '0;
      ack_one[ch_q] = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) begin
            sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
            sel_len  = ch_len[i*2 +: 2];
            sel_we   = ch_we[i];
            sel_wd   = ch_wdata[i*32 +: 32];
         end
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // next state; a frozen read is parked at the start of XFER
   always_comb begin
      state_d = state_q;
      if (rdy) begin
         unique case (state_q)
            ST_IDLE: if (gnt_vld) state_d = ST_XFER;
            ST_XFER: begin
               if (abort)
                  state_d = ST_IDLE;
               else if (!io_stall && last)
                  state_d = we_q ? ST_IDLE : ST_TAIL;
            end
            ST_TAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE && !we_q) begin
         state_d = ST_XFER;
      end
   end

   // latch request, step byte counter, assemble read word, raise ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         nb_q    <= 3'd1;
         we_q    <= 1'b0;
         wdata_q <= '0;
         ch_q    <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         rdata_q <= '0;
         ack_q   <= '0;
      end else if (rdy) begin
         ack_q <= '0;
         unique case (state_q)
            ST_IDLE: begin
               if (gnt_vld) begin
                  addr_q  <= sel_addr;
                  nb_q    <= len_bytes(sel_len);
                  we_q    <= sel_we;
                  wdata_q <= sel_wd;
                  ch_q    <= gnt_idx;
                  cnt_q   <= '0;
                  buf_q   <= '0;
               end
            end
            ST_XFER: begin
               if (!abort && !io_stall) begin
                  cnt_q <= cnt_q + 3'd1;
                  if (!we_q && cnt_q != 3'd0)
                     buf_q <= buf_nx;
                  if (we_q && last)
                     ack_q <= ack_one;
               end
            end
            ST_TAIL: begin
               if (!abort) begin
                  rdata_q <= buf_nx;
                  ack_q   <= ack_one;
               end
            end
            default: ;
         endcase
      end else if (state_q != ST_IDLE && !we_q) begin
         cnt_q <= '0;
         buf_q <= '0;
      end
   end

   assign mem_a    = (state_q == ST_XFER) ? addr_q + ADDR_W'(cnt_q) : '0;
   assign mem_wr   = rdy && (state_q == ST_XFER) && we_q && !io_stall;
   assign mem_dout = mem_wr ? wsh[7:0] : 8'h00;
   assign ch_ack   = ack_q & {NUM_CH{rdy}} & ~({NUM_CH{clr}} & FLUSH_MASK);
   assign ch_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Directed bench for mem_arbiter_nch: reads, writes, fairness,
// IO stall, flush abort and rdy freeze against hand-computed cycles.
module tb_mem_arbiter_nch;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        clr;
   logic [1:0]  ch_req;
   logic [1:0]  ch_we;
   logic [63:0] ch_addr;
   logic [3:0]  ch_len;
   logic [63:0] ch_wdata;
   logic [1:0]  ch_ack;
   logic [31:0] ch_rdata;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] ram [0:1023];

   mem_arbiter_nch dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .clr            (clr),
      .ch_req         (ch_req),
      .ch_we          (ch_we),
      .ch_addr        (ch_addr),
      .ch_len         (ch_len),
      .ch_wdata       (ch_wdata),
      .ch_ack         (ch_ack),
      .ch_rdata       (ch_rdata),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_buffer_full)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_din <= ram[mem_a[9:0]];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_ch(input int i, input logic we, input logic [31:0] a,
                         input logic [1:0] len, input logic [31:0] wd);
      ch_we[i]           = we;
      ch_addr[i*32 +: 32] = a;
      ch_len[i*2 +: 2]    = len;
      ch_wdata[i*32 +: 32] = wd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] t3_ack [0:11];
   logic       t3_wr  [0:11];

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[256] = 8'h11;
      ram[257] = 8'h22;
      ram[258] = 8'h33;
      ram[259] = 8'h44;
      mem_din = 8'h00;
      rst = 1'b0; rdy = 1'b1; clr = 1'b0;
      ch_req = '0; ch_we = '0; ch_addr = '0; ch_len = '0; ch_wdata = '0;
      io_buffer_full = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ack", 32'(ch_ack), 32'h0);
      check("rst_rdata", ch_rdata, 32'h0);
      check("rst_a", mem_a, 32'h0);
      check("rst_dout", 32'(mem_dout), 32'h0);
      check("rst_wr", 32'(mem_wr), 32'h0);
      next_cycle();
      rst = 1'b1;
      next_cycle();

      // 4 B read on ch1
      set_ch(1, 1'b0, 32'h100, 2'b10, 32'h0);
      ch_req = 2'b10;
      for (int c = 0; c <= 7; c++) begin
         if (c == 7) ch_req = 2'b00;
         @(negedge clk);
         if (c >= 1 && c <= 4) begin
            check("rd4_a", mem_a, 32'h100 + 32'(c - 1));
            check("rd4_wr", 32'(mem_wr), 32'h0);
         end
         if (c == 5) check("rd4_noack", 32'(ch_ack), 32'h0);
         if (c == 6) begin
            check("rd4_ack", 32'(ch_ack), 32'h2);
            check("rd4_data", ch_rdata, 32'h44332211);
         end
         if (c == 7) check("rd4_idle", mem_a, 32'h0);
         next_cycle();
      end

      // 2 B write on ch1
      set_ch(1, 1'b1, 32'h200, 2'b01, 32'h0000BEEF);
      ch_req = 2'b10;
      for (int c = 0; c <= 4; c++) begin
         if (c == 4) ch_req = 2'b00;
         @(negedge clk);
         if (c == 0) check("wr2_c0_a", mem_a, 32'h0);
         if (c == 1) begin
            check("wr2_c1_a", mem_a, 32'h200);
            check("wr2_c1_d", 32'(mem_dout), 32'hEF);
            check("wr2_c1_wr", 32'(mem_wr), 32'h1);
         end
         if (c == 2) begin
            check("wr2_c2_a", mem_a, 32'h201);
            check("wr2_c2_d", 32'(mem_dout), 32'hBE);
            check("wr2_c2_wr", 32'(mem_wr), 32'h1);
         end
         if (c == 3) begin
            check("wr2_ack", 32'(ch_ack), 32'h2);
            check("wr2_c3_wr", 32'(mem_wr), 32'h0);
         end
         if (c == 4) check("wr2_noack", 32'(ch_ack), 32'h0);
         next_cycle();
      end

      // fairness: ch0 1 B read, ch1 1 B write, both requesting
      t3_ack = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10,
                 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      t3_wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      set_ch(0, 1'b0, 32'h100, 2'b00, 32'h0);
      set_ch(1, 1'b1, 32'h300, 2'b00, 32'h5A);
      ch_req = 2'b11;
      for (int c = 0; c <= 11; c++) begin
         if (c == 9)  ch_req = 2'b10;
         if (c == 11) ch_req = 2'b00;
         @(negedge clk);
         check($sformatf("rr_ack_c%0d", c), 32'(ch_ack), 32'(t3_ack[c]));
         check($sformatf("rr_wr_c%0d", c), 32'(mem_wr), 32'(t3_wr[c]));
         if (c == 3 || c == 8) check("rr_rdata", ch_rdata, 32'h11);
         if (c == 4 || c == 9) begin
            check("rr_wa", mem_a, 32'h300);
            check("rr_wd", 32'(mem_dout), 32'h5A);
         end
         if (c == 6) check("rr_ra", mem_a, 32'h100);
         next_cycle();
      end

      // IO write stalled by a full UART buffer
      set_ch(1, 1'b1, 32'h30000, 2'b00, 32'h41);
      ch_req = 2'b10;
      for (int c = 0; c <= 6; c++) begin
         io_buffer_full = (c >= 1 && c <= 3);
         if (c == 6) ch_req = 2'b00;
         @(negedge clk);
         if (c >= 1 && c <= 3) begin
            check("io_stall_wr", 32'(mem_wr), 32'h0);
            check("io_stall_a", mem_a, 32'h30000);
         end
         if (c == 4) begin
            check("io_wr", 32'(mem_wr), 32'h1);
            check("io_dout", 32'(mem_dout), 32'h41);
         end
         if (c == 5) begin
            check("io_ack", 32'(ch_ack), 32'h2);
            check("io_wr_done", 32'(mem_wr), 32'h0);
         end
         if (c == 6) check("io_noack", 32'(ch_ack), 32'h0);
         next_cycle();
      end

      // flush aborts ch0 read; pending ch1 store goes next
      set_ch(0, 1'b0, 32'h100, 2'b10, 32'h0);
      set_ch(1, 1'b1, 32'h304, 2'b00, 32'h77);
      ch_req = 2'b11;
      for (int c = 0; c <= 8; c++) begin
         clr = (c == 3);
         if (c == 3) ch_req = 2'b10;
         if (c == 7) ch_req = 2'b00;
         @(negedge clk);
         if (c >= 3) check($sformatf("clr_no_ack0_c%0d", c),
                           32'(ch_ack[0]), 32'h0);
         if (c == 4) check("clr_idle_a", mem_a, 32'h0);
         if (c == 5) begin
            check("clr_st_a", mem_a, 32'h304);
            check("clr_st_d", 32'(mem_dout), 32'h77);
            check("clr_st_wr", 32'(mem_wr), 32'h1);
         end
         if (c == 6) begin
            check("clr_st_ack", 32'(ch_ack), 32'h2);
            check("clr_rdata_kept", ch_rdata, 32'h11);
         end
         next_cycle();
      end
      clr = 1'b0;

      // rdy low during cycles 2-4 of a 4 B read
      set_ch(0, 1'b0, 32'h100, 2'b10, 32'h0);
      ch_req = 2'b01;
      for (int c = 0; c <= 13; c++) begin
         rdy = !(c >= 2 && c <= 4);
         if (c == 11) ch_req = 2'b00;
         @(negedge clk);
         check($sformatf("frz_ack_c%0d", c), 32'(ch_ack),
               (c == 10) ? 32'h1 : 32'h0);
         if (c >= 2 && c <= 4) check("frz_wr", 32'(mem_wr), 32'h0);
         if (c >= 5 && c <= 8) check("frz_a", mem_a, 32'h100 + 32'(c - 5));
         if (c == 10) check("frz_rdata", ch_rdata, 32'h44332211);
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
